// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state type and seven-segment constants for lock_controller
package lock_pkg;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_t;

   localparam logic [8:0] SEG_L   = 9'h038;
   localparam logic [8:0] SEG_O   = 9'h03f;
   localparam logic [8:0] SEG_E   = 9'h079;
   localparam logic [8:0] SEG_ALL = 9'h07f;

   function automatic logic [8:0] seg_digit(input logic [3:0] d);
      logic [8:0] r;
      case (d)
         4'd0:    r = 9'h03f;
         4'd1:    r = 9'h006;
         4'd2:    r = 9'h05b;
         4'd3:    r = 9'h04f;
         4'd4:    r = 9'h066;
         4'd5:    r = 9'h06d;
         4'd6:    r = 9'h07d;
         4'd7:    r = 9'h007;
         4'd8:    r = 9'h07f;
         4'd9:    r = 9'h06f;
         default: r = 9'h000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - coded lock sequencer with timed open window and alarm lockout
module lock_controller
   import lock_pkg::*;
#(
   parameter logic [3:0] PASSWORD       = 4'b0101,
   parameter int         MAX_TRIES      = 3,
   parameter int         OPEN_CYCLES    = 24_000_000,
   parameter int         LOCKOUT_CYCLES = 120_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] code,
   input  logic       key_pulse,
   output logic       led1,
   output logic       led2,
   output logic [8:0] seg_led_1,
   output logic [8:0] seg_led_2,
   output logic [1:0] state_o
);

   localparam int MAX_CYCLES = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES + 1);

   localparam logic [TW-1:0] OPEN_LOAD    = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]    TRIES_FULL   = 4'(MAX_TRIES);

   lock_state_t   r_state, w_next_state;
   logic [3:0]    r_tries, w_next_tries;
   logic [TW-1:0] r_timer, w_next_timer;

   logic          r_led1, r_led2, w_led1, w_led2;
   logic [8:0]    r_seg1, r_seg2, w_seg1, w_seg2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= LOCKED;
         r_tries <= TRIES_FULL;
         r_timer <= '0;
         r_led1  <= 1'b1;
         r_led2  <= 1'b1;
         r_seg1  <= seg_digit(TRIES_FULL);
         r_seg2  <= SEG_L;
      end else begin
         r_state <= w_next_state;
         r_tries <= w_next_tries;
         r_timer <= w_next_timer;
         r_led1  <= w_led1;
         r_led2  <= w_led2;
         r_seg1  <= w_seg1;
         r_seg2  <= w_seg2;
      end
   end

   // Expiry is tested before key_pulse so a coincident pulse never reopens or re-evaluates.
   always_comb begin
      w_next_state = r_state;
      w_next_tries = r_tries;
      w_next_timer = r_timer;
      case (r_state)
         LOCKED: begin
            if (key_pulse) begin
               if (code == PASSWORD) begin
                  w_next_state = OPEN;
                  w_next_timer = OPEN_LOAD;
                  w_next_tries = TRIES_FULL;
               end else if (r_tries > 4'd1) begin
                  w_next_tries = r_tries - 4'd1;
               end else begin
                  w_next_state = LOCKOUT;
                  w_next_tries = 4'd0;
                  w_next_timer = LOCKOUT_LOAD;
               end
            end
         end
         OPEN: begin
            if (r_timer == '0) begin
               w_next_state = LOCKED;
            end else if (key_pulse) begin
               w_next_state = LOCKED;
               w_next_timer = '0;
            end else begin
               w_next_timer = r_timer - 1'b1;
            end
         end
         LOCKOUT: begin
            if (r_timer == '0) begin
               w_next_state = LOCKED;
               w_next_tries = TRIES_FULL;
            end else begin
               w_next_timer = r_timer - 1'b1;
            end
         end
         default: begin
            w_next_state = LOCKED;
            w_next_tries = TRIES_FULL;
            w_next_timer = '0;
         end
      endcase
   end

   always_comb begin
      w_led1 = 1'b1;
      w_led2 = 1'b1;
      w_seg1 = seg_digit(w_next_tries);
      w_seg2 = SEG_L;
      case (w_next_state)
         OPEN: begin
            w_led1 = 1'b0;
            w_seg1 = SEG_ALL;
            w_seg2 = SEG_O;
         end
         LOCKOUT: begin
            w_led2 = 1'b0;
            w_seg1 = SEG_O;
            w_seg2 = SEG_E;
         end
         default: begin
            w_led1 = 1'b1;
         end
      endcase
   end

   assign led1      = r_led1;
   assign led2      = r_led2;
   assign seg_led_1 = r_seg1;
   assign seg_led_2 = r_seg2;
   assign state_o   = r_state;

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - directed and randomized checks of lock_controller against a deadline-based model
module tb_lock_controller;

   localparam logic [3:0] PW = 4'b0101;
   localparam int MT = 3;
   localparam int OC = 8;
   localparam int LC = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] code = 4'd0;
   logic       key_pulse = 1'b0;
   logic       led1, led2;
   logic [8:0] seg_led_1, seg_led_2;
   logic [1:0] state_o;

   int checks = 0;
   int failures = 0;

   // Model: mode 0 locked, 1 open, 2 lockout; timed modes end at an absolute edge number.
   int m_mode = 0;
   int m_tries = MT;
   int m_deadline = 0;
   int cyc = 0;

   logic [8:0] digits [0:9] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                                9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

   lock_controller #(
      .PASSWORD(PW),
      .MAX_TRIES(MT),
      .OPEN_CYCLES(OC),
      .LOCKOUT_CYCLES(LC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .code(code),
      .key_pulse(key_pulse),
      .led1(led1),
      .led2(led2),
      .seg_led_1(seg_led_1),
      .seg_led_2(seg_led_2),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_tries = MT;
      m_deadline = 0;
   endtask

   task automatic model_edge(input logic p, input logic [3:0] c);
      cyc++;
      case (m_mode)
         0: if (p) begin
               if (c == PW) begin
                  m_mode = 1; m_tries = MT; m_deadline = cyc + OC;
               end else if (m_tries > 1) begin
                  m_tries--;
               end else begin
                  m_mode = 2; m_tries = 0; m_deadline = cyc + LC;
               end
            end
         1: if (cyc == m_deadline || p) m_mode = 0;
         default: if (cyc == m_deadline) begin
               m_mode = 0; m_tries = MT;
            end
      endcase
   endtask

   task automatic check_all(input string tag);
      logic [8:0] e1, e2;
      e1 = (m_mode == 0) ? digits[m_tries] : (m_mode == 1) ? 9'h07f : 9'h03f;
      e2 = (m_mode == 0) ? 9'h038 : (m_mode == 1) ? 9'h03f : 9'h079;
      chk({tag, ".state"}, 9'(state_o), 9'(m_mode));
      chk({tag, ".led1"}, 9'(led1), (m_mode == 1) ? 9'd0 : 9'd1);
      chk({tag, ".led2"}, 9'(led2), (m_mode == 2) ? 9'd0 : 9'd1);
      chk({tag, ".seg1"}, seg_led_1, e1);
      chk({tag, ".seg2"}, seg_led_2, e2);
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic tick(input string tag, input logic p, input logic [3:0] c);
      key_pulse = p;
      code = c;
      @(posedge clk);
      model_edge(p, c);
      #1 key_pulse = 1'b0;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 1'b0, 4'($urandom));
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      check_all("reset");
      chk("reset.seg1_lit", seg_led_1, 9'h04f);
      @(negedge clk);
      rst = 1'b1;

      // 1: correct code, open window of exactly OC cycles
      tick("t1.open", 1'b1, PW);
      chk("t1.seg2_lit", seg_led_2, 9'h03f);
      idle("t1.hold", OC - 1);
      chk("t1.still_open", 9'(led1), 9'd0);
      idle("t1.expire", 1);
      chk("t1.closed_seg1", seg_led_1, 9'h04f);

      // 2: wrong-code countdown into lockout and back
      tick("t2.w1", 1'b1, 4'b0000);
      chk("t2.seg1_2", seg_led_1, 9'h05b);
      tick("t2.w2", 1'b1, 4'b0000);
      chk("t2.seg1_1", seg_led_1, 9'h006);
      tick("t2.w3", 1'b1, 4'b0000);
      chk("t2.seg2_E", seg_led_2, 9'h079);
      idle("t2.lockout", LC);
      chk("t2.led2_off", 9'(led2), 9'd1);

      // 3: correct-code pulses during lockout are ignored, including the expiry cycle
      for (int i = 0; i < 3; i++) tick("t3.enter", 1'b1, 4'b1111);
      for (int i = 0; i < LC - 1; i++) tick("t3.pulses", i[0], PW);
      tick("t3.expiry_pulse", 1'b1, PW);
      chk("t3.locked", 9'(state_o), 9'd0);

      // 4: early close at timer 5, then pulse coincident with expiry
      tick("t4.open", 1'b1, PW);
      idle("t4.wait", 2);
      tick("t4.early", 1'b1, 4'b0011);
      tick("t4.reopen", 1'b1, PW);
      idle("t4.wait2", OC - 1);
      tick("t4.collide", 1'b1, PW);
      chk("t4.not_reopened", 9'(led1), 9'd1);

      // 5: success restores tries
      tick("t5.w1", 1'b1, 4'b1000);
      tick("t5.w2", 1'b1, 4'b1000);
      tick("t5.ok", 1'b1, PW);
      idle("t5.open", OC);
      chk("t5.seg1_full", seg_led_1, 9'h04f);
      tick("t5.w3", 1'b1, 4'b1000);
      chk("t5.seg1_2", seg_led_1, 9'h05b);

      // 6: asynchronous reset mid-lockout and mid-open
      tick("t6.w1", 1'b1, 4'b0000);
      tick("t6.w2", 1'b1, 4'b0000);
      idle("t6.lockout", 3);
      async_reset("t6.rst_lockout");
      tick("t6.open", 1'b1, PW);
      idle("t6.open_hold", 2);
      async_reset("t6.rst_open");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic p;
         logic [3:0] c;
         p = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 1) == 0) ? PW : 4'($urandom);
         tick("rand", p, c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
